// File: rtl/sram_spi_controller_if.sv
// Audio requester port and external SRAM pins shared by the SRAM sequencer.
// The controller takes the master modport; the audio engine / SRAM side takes slave.
interface sram_spi_controller_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  // aud_req is a level request; a transfer happens in every cycle where aud_req
  // and aud_gnt are both high, and aud_* may change on the edge after that cycle.
  logic              aud_req;
  logic              aud_we;
  logic [ADDR_W-1:0] aud_addr;
  logic [DATA_W-1:0] aud_wdata;
  logic              aud_gnt;
  logic [DATA_W-1:0] aud_rdata;
  logic              aud_rvalid;
  logic              sram_en;
  logic              sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;

  modport master (
    input  aud_req, aud_we, aud_addr, aud_wdata, sram_rdata,
    output aud_gnt, aud_rdata, aud_rvalid, sram_en, sram_we, sram_addr, sram_wdata
  );

  modport slave (
    output aud_req, aud_we, aud_addr, aud_wdata, sram_rdata,
    input  aud_gnt, aud_rdata, aud_rvalid, sram_en, sram_we, sram_addr, sram_wdata
  );
endinterface

// File: rtl/sram_spi_controller.sv
// Arbitrates the single-port SRAM between the SPI register path and the audio
// datapath, keeping the SPI auto-increment pointer and a one-byte read prefetch.
module sram_spi_controller #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 8,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load_addr_stb,
  input  logic                spi_wr_req,
  input  logic                spi_rd_req,
  input  logic                rd_mode,
  input  logic [ADDR_W-9:0]   page,
  input  logic [7:0]          start_offset,
  input  logic [DATA_W-1:0]   spi_wdata,
  output logic [DATA_W-1:0]   sram_to_spi_data,
  output logic                spi_rd_valid,
  output logic                spi_busy,
  output logic                spi_overrun,
  input  logic                overrun_clr,
  output logic [1:0]          dbg_state,
  sram_spi_controller_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WR_PEND = 2'd1,
    S_RD_PEND = 2'd2,
    S_RD_WAIT = 2'd3
  } state_e;

  localparam int WAIT_W = $clog2(STARVE_LIMIT) + 1;
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_LIMIT - 1);

  state_e            state_q, state_d;
  logic [7:0]        ptr_q, ptr_d;
  logic [DATA_W-1:0] wbuf_q, wbuf_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [DATA_W-1:0] spi_data_q, spi_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              overrun_q, overrun_d;
  logic              spi_p1_q, spi_p1_d, spi_p2_q, spi_p2_d;
  logic              aud_p1_q, aud_p1_d, aud_p2_q, aud_p2_d;
  logic              aud_rvalid_q, aud_rvalid_d;
  logic [DATA_W-1:0] aud_rdata_q, aud_rdata_d;
  logic              en_q, en_d, we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic spi_pend, starved, spi_gnt, aud_gnt_c, rd_ev, ovr_set;

  always_comb begin
    spi_pend  = (state_q == S_WR_PEND) || (state_q == S_RD_PEND);
    starved   = (wait_q >= WAIT_MAX);
    spi_gnt   = spi_pend && (!bus.aud_req || starved);
    aud_gnt_c = bus.aud_req && !spi_gnt;
    rd_ev     = spi_rd_req && rd_mode;

    state_d      = state_q;
    ptr_d        = ptr_q;
    wbuf_d       = wbuf_q;
    spi_data_d   = spi_data_q;
    rd_valid_d   = rd_valid_q;
    ovr_set      = 1'b0;
    en_d         = 1'b0;
    we_d         = 1'b0;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    spi_p1_d     = 1'b0;
    spi_p2_d     = spi_p1_q;
    aud_p1_d     = 1'b0;
    aud_p2_d     = aud_p1_q;
    aud_rvalid_d = aud_p2_q;
    aud_rdata_d  = aud_p2_q ? bus.sram_rdata : aud_rdata_q;

    // Only one SPI request is accepted per idle cycle; anything else is an overrun.
    case (state_q)
      S_IDLE: begin
        if (load_addr_stb) begin
          ptr_d   = start_offset;
          ovr_set = spi_wr_req || rd_ev;
          if (rd_mode) begin
            state_d    = S_RD_PEND;
            rd_valid_d = 1'b0;
          end
        end else if (spi_wr_req) begin
          wbuf_d  = spi_wdata;
          state_d = S_WR_PEND;
          ovr_set = rd_ev;
        end else if (rd_ev) begin
          state_d    = S_RD_PEND;
          rd_valid_d = 1'b0;
        end
      end
      S_WR_PEND: begin
        ovr_set = load_addr_stb || spi_wr_req || rd_ev;
        if (spi_gnt) state_d = S_IDLE;
      end
      S_RD_PEND: begin
        ovr_set = load_addr_stb || spi_wr_req || rd_ev;
        if (spi_gnt) state_d = S_RD_WAIT;
      end
      default: begin
        ovr_set = load_addr_stb || spi_wr_req || rd_ev;
        if (spi_p2_q) begin
          spi_data_d = bus.sram_rdata;
          rd_valid_d = 1'b1;
          state_d    = S_IDLE;
        end
      end
    endcase

    overrun_d = ovr_set ? 1'b1 : (overrun_clr ? 1'b0 : overrun_q);

    if (spi_gnt) begin
      en_d     = 1'b1;
      we_d     = (state_q == S_WR_PEND);
      addr_d   = {page, ptr_q};
      wdata_d  = wbuf_q;
      ptr_d    = ptr_q + 8'd1;
      spi_p1_d = (state_q == S_RD_PEND);
    end else if (aud_gnt_c) begin
      en_d     = 1'b1;
      we_d     = bus.aud_we;
      addr_d   = bus.aud_addr;
      wdata_d  = bus.aud_wdata;
      aud_p1_d = !bus.aud_we;
    end

    if (spi_pend && !spi_gnt) wait_d = starved ? wait_q : wait_q + WAIT_W'(1);
    else                      wait_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      wbuf_q       <= '0;
      wait_q       <= '0;
      spi_data_q   <= '0;
      rd_valid_q   <= 1'b0;
      overrun_q    <= 1'b0;
      spi_p1_q     <= 1'b0;
      spi_p2_q     <= 1'b0;
      aud_p1_q     <= 1'b0;
      aud_p2_q     <= 1'b0;
      aud_rvalid_q <= 1'b0;
      aud_rdata_q  <= '0;
      en_q         <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      wbuf_q       <= wbuf_d;
      wait_q       <= wait_d;
      spi_data_q   <= spi_data_d;
      rd_valid_q   <= rd_valid_d;
      overrun_q    <= overrun_d;
      spi_p1_q     <= spi_p1_d;
      spi_p2_q     <= spi_p2_d;
      aud_p1_q     <= aud_p1_d;
      aud_p2_q     <= aud_p2_d;
      aud_rvalid_q <= aud_rvalid_d;
      aud_rdata_q  <= aud_rdata_d;
      en_q         <= en_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

  assign sram_to_spi_data = spi_data_q;
  assign spi_rd_valid     = rd_valid_q;
  assign spi_busy         = (state_q != S_IDLE);
  assign spi_overrun      = overrun_q;
  assign dbg_state        = state_q;
  assign bus.aud_gnt      = aud_gnt_c;
  assign bus.aud_rdata    = aud_rdata_q;
  assign bus.aud_rvalid   = aud_rvalid_q;
  assign bus.sram_en      = en_q;
  assign bus.sram_we      = we_q;
  assign bus.sram_addr    = addr_q;
  assign bus.sram_wdata   = wdata_q;

endmodule

// File: tb/tb_sram_spi_controller.sv
// Directed bench for sram_spi_controller: SRAM behavioural model, write log
// scoreboard and hand-computed expectations for each scenario.
module tb_sram_spi_controller;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
  localparam int W      = ADDR_W + DATA_W;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              load_addr_stb = 1'b0;
  logic              spi_wr_req = 1'b0;
  logic              spi_rd_req = 1'b0;
  logic              rd_mode = 1'b0;
  logic [7:0]        page = '0;
  logic [7:0]        start_offset = '0;
  logic [DATA_W-1:0] spi_wdata = '0;
  logic              overrun_clr = 1'b0;
  logic [DATA_W-1:0] sram_to_spi_data;
  logic              spi_rd_valid, spi_busy, spi_overrun;
  logic [1:0]        dbg_state;

  sram_spi_controller_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) sif ();

  sram_spi_controller #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(8)) dut (
    .clk              (clk),
    .reset            (reset),
    .load_addr_stb    (load_addr_stb),
    .spi_wr_req       (spi_wr_req),
    .spi_rd_req       (spi_rd_req),
    .rd_mode          (rd_mode),
    .page             (page),
    .start_offset     (start_offset),
    .spi_wdata        (spi_wdata),
    .sram_to_spi_data (sram_to_spi_data),
    .spi_rd_valid     (spi_rd_valid),
    .spi_busy         (spi_busy),
    .spi_overrun      (spi_overrun),
    .overrun_clr      (overrun_clr),
    .dbg_state        (dbg_state),
    .bus              (sif.master)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  // SRAM model and write log
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [W-1:0]      wr_log [0:63];
  int                wr_cnt = 0;

  initial sif.sram_rdata = '0;

  always @(posedge clk) begin
    if (sif.sram_en) begin
      if (sif.sram_we) begin
        mem[sif.sram_addr] <= sif.sram_wdata;
        if (wr_cnt < 64) wr_log[wr_cnt] <= {sif.sram_addr, sif.sram_wdata};
        wr_cnt <= wr_cnt + 1;
      end else begin
        sif.sram_rdata <= mem[sif.sram_addr];
      end
    end
  end

  // scoreboard
  logic [W-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int wr_seen = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_writes(input string tag);
    logic [W-1:0]  e;
    logic [31:0]   g;
    check_eq({tag, "_count"}, 32'(wr_cnt - wr_seen), 32'(exp_q.size()));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (wr_seen < wr_cnt) ? 32'(wr_log[wr_seen]) : 32'h0100_0000;
      check_eq({tag, "_entry"}, g, 32'(e));
      wr_seen++;
    end
    wr_seen = wr_cnt;
  endtask

  // drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic spi_load(input logic [7:0] pg, input logic [7:0] off, input logic rdm);
    page = pg; start_offset = off; rd_mode = rdm; load_addr_stb = 1'b1;
    tick();
    load_addr_stb = 1'b0;
  endtask

  task automatic spi_write(input logic [7:0] d);
    spi_wdata = d; spi_wr_req = 1'b1;
    tick();
    spi_wr_req = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (spi_busy && n < 50) begin
      tick();
      n++;
    end
    check_eq(tag, {31'b0, spi_busy}, 32'd0);
  endtask

  initial begin
    sif.aud_req = 1'b0; sif.aud_we = 1'b0; sif.aud_addr = '0; sif.aud_wdata = '0;

    // reset state
    repeat (3) tick();
    check_eq("rst_busy", {31'b0, spi_busy}, 0);
    check_eq("rst_valid", {31'b0, spi_rd_valid}, 0);
    check_eq("rst_en", {31'b0, sif.sram_en}, 0);
    check_eq("rst_state", {30'b0, dbg_state}, 0);
    reset = 1'b0;
    tick();

    // write stream with offset wrap, page fixed
    spi_load(8'h12, 8'hFE, 1'b0);
    spi_write(8'hA1); wait_idle("wr1_idle");
    spi_write(8'hA2); wait_idle("wr2_idle");
    spi_write(8'hA3); wait_idle("wr3_idle");
    tick(); tick();
    exp_q.push_back({16'h12FE, 8'hA1});
    exp_q.push_back({16'h12FF, 8'hA2});
    exp_q.push_back({16'h1200, 8'hA3});
    check_writes("wrap_writes");

    // read stream: preload, prefetch, then consume
    spi_load(8'h12, 8'h40, 1'b0);
    spi_write(8'h5A); wait_idle("pre1_idle");
    spi_write(8'hC3); wait_idle("pre2_idle");
    tick();
    exp_q.push_back({16'h1240, 8'h5A});
    exp_q.push_back({16'h1241, 8'hC3});
    check_writes("preload");
    spi_load(8'h12, 8'h40, 1'b1);
    wait_idle("prefetch_idle");
    check_eq("prefetch_valid", {31'b0, spi_rd_valid}, 1);
    check_eq("prefetch_data", {24'b0, sram_to_spi_data}, 32'h5A);
    spi_rd_req = 1'b1;
    tick();
    spi_rd_req = 1'b0;
    check_eq("rd_cleared", {31'b0, spi_rd_valid}, 0);
    tick(); tick();
    check_eq("rd_not_early", {31'b0, spi_rd_valid}, 0);
    tick();
    check_eq("rd_valid_4", {31'b0, spi_rd_valid}, 1);
    check_eq("rd_data", {24'b0, sram_to_spi_data}, 32'hC3);

    // starvation override under continuous audio reads
    spi_load(8'h12, 8'h80, 1'b0);
    sif.aud_req = 1'b1; sif.aud_we = 1'b0; sif.aud_addr = 16'h3000;
    spi_write(8'h3C);
    for (int i = 1; i <= 7; i++) begin
      check_eq($sformatf("starve_aud_gnt_c%0d", i), {31'b0, sif.aud_gnt}, 1);
      tick();
    end
    check_eq("starve_spi_wins", {31'b0, sif.aud_gnt}, 0);
    check_eq("starve_busy", {31'b0, spi_busy}, 1);
    tick();
    check_eq("starve_aud_resume", {31'b0, sif.aud_gnt}, 1);
    check_eq("starve_idle", {31'b0, spi_busy}, 0);
    check_eq("starve_strobe", {15'b0, sif.sram_en, sif.sram_we, sif.sram_addr}, {15'b0, 1'b1, 1'b1, 16'h1280});
    sif.aud_req = 1'b0;
    repeat (4) tick();
    exp_q.push_back({16'h1280, 8'h3C});
    check_writes("starve_write");

    // audio write then read back
    sif.aud_req = 1'b1; sif.aud_we = 1'b1; sif.aud_addr = 16'h0100; sif.aud_wdata = 8'h77;
    #1;
    check_eq("aud_wr_gnt", {31'b0, sif.aud_gnt}, 1);
    tick();
    sif.aud_req = 1'b0; sif.aud_we = 1'b0;
    tick();
    sif.aud_req = 1'b1;
    #1;
    check_eq("aud_rd_gnt", {31'b0, sif.aud_gnt}, 1);
    tick();
    sif.aud_req = 1'b0;
    check_eq("aud_rd_strobe", {14'b0, sif.sram_en, sif.sram_we, sif.sram_addr}, {14'b0, 1'b1, 1'b0, 16'h0100});
    tick();
    check_eq("aud_rvalid_early", {31'b0, sif.aud_rvalid}, 0);
    tick();
    check_eq("aud_rvalid_t3", {31'b0, sif.aud_rvalid}, 1);
    check_eq("aud_rdata", {24'b0, sif.aud_rdata}, 32'h77);
    tick();
    check_eq("aud_rvalid_once", {31'b0, sif.aud_rvalid}, 0);
    exp_q.push_back({16'h0100, 8'h77});
    check_writes("aud_write");

    // overrun: second write dropped, set beats a simultaneous clear
    spi_load(8'h12, 8'h90, 1'b0);
    sif.aud_req = 1'b1; sif.aud_addr = 16'h3000;
    spi_wdata = 8'h11; spi_wr_req = 1'b1;
    tick();
    spi_wdata = 8'h22; overrun_clr = 1'b1;
    tick();
    spi_wr_req = 1'b0; overrun_clr = 1'b0;
    check_eq("ovr_set", {31'b0, spi_overrun}, 1);
    wait_idle("ovr_idle");
    check_eq("ovr_sticky", {31'b0, spi_overrun}, 1);
    sif.aud_req = 1'b0;
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    check_eq("ovr_cleared", {31'b0, spi_overrun}, 0);
    repeat (4) tick();
    exp_q.push_back({16'h1290, 8'h11});
    check_writes("ovr_write");

    // reset while waiting for read data
    spi_load(8'h12, 8'h40, 1'b1);
    tick();
    check_eq("rw_state", {30'b0, dbg_state}, 32'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("rw_busy", {31'b0, spi_busy}, 0);
    check_eq("rw_en", {31'b0, sif.sram_en}, 0);
    check_eq("rw_valid", {31'b0, spi_rd_valid}, 0);
    check_eq("rw_data", {24'b0, sram_to_spi_data}, 0);
    check_eq("rw_ovr", {31'b0, spi_overrun}, 0);
    tick();
    check_eq("rw_no_strobe", {31'b0, sif.sram_en}, 0);
    check_eq("rw_no_valid", {31'b0, spi_rd_valid}, 0);
    spi_load(8'h12, 8'h41, 1'b1);
    wait_idle("rw_fresh_idle");
    check_eq("rw_fresh_valid", {31'b0, spi_rd_valid}, 1);
    check_eq("rw_fresh_data", {24'b0, sram_to_spi_data}, 32'hC3);

    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
